// File: rtl/dii_package.sv
// Shared DII flit definitions used by the packet buffer and its flit FIFO.
package dii_package;
   localparam int DII_WIDTH = 16;

   typedef struct packed {
      logic                 first;
      logic                 last;
      logic [DII_WIDTH-1:0] data;
   } dii_flit;
endpackage

// File: rtl/dii_flit_fifo.sv
// Circular flit store: memory, read/write pointers and fill level with full/empty flags.
module dii_flit_fifo #(
   parameter int WIDTH = 18,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int FW = $clog2(DEPTH + 1);
   localparam logic [FW-1:0] FULL_FILL = FW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [FW-1:0]    fill;
   logic             do_wr;
   logic             do_rd;

   assign full    = (fill == FULL_FILL);
   assign empty   = (fill == '0);
   assign do_wr   = wr_en & ~full;
   assign do_rd   = rd_en & ~empty;
   assign rd_data = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         fill   <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
         case ({do_wr, do_rd})
            2'b10:   fill <= fill + 1'b1;
            2'b01:   fill <= fill - 1'b1;
            default: fill <= fill;
         endcase
      end
   end

   // NOTE: storage is deliberately left out of reset; fill==0 already marks it invalid.
   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= wr_data;
   end
endmodule

// File: rtl/dii_packet_buffer.sv
// DII packet buffer: flit FIFO plus complete-packet counter and store-and-forward gating.
module dii_packet_buffer
   import dii_package::*;
#(
   parameter int WIDTH      = DII_WIDTH,
   parameter int BUF_SIZE   = 8,
   parameter int FULLPACKET = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [WIDTH-1:0]              in_data,
   input  logic                          in_first,
   input  logic                          in_last,
   input  logic                          in_valid,
   output logic                          in_ready,
   output logic [WIDTH-1:0]              out_data,
   output logic                          out_first,
   output logic                          out_last,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [$clog2(BUF_SIZE+1)-1:0] pkt_count
);
   typedef struct packed {
      logic             first;
      logic             last;
      logic [WIDTH-1:0] data;
   } flit_t;

   flit_t wr_flit;
   flit_t rd_flit;
   logic  full;
   logic  empty;
   logic  active;
   logic  push;
   logic  pop;

   assign wr_flit = '{first: in_first, last: in_last, data: in_data};

   dii_flit_fifo #(
      .WIDTH ($bits(flit_t)),
      .DEPTH (BUF_SIZE)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (push),
      .wr_data (wr_flit),
      .rd_en   (pop),
      .rd_data (rd_flit),
      .full    (full),
      .empty   (empty)
   );

   // Holds in_ready low throughout reset even though the FIFO already reads empty.
   always_ff @(posedge clk) begin
      if (!rst) active <= 1'b0;
      else      active <= 1'b1;
   end

   assign in_ready = active & ~full;
   assign push     = in_valid & in_ready;
   assign pop      = out_valid & out_ready;

   always_ff @(posedge clk) begin
      if (!rst) begin
         pkt_count <= '0;
      end else begin
         case ({push & in_last, pop & rd_flit.last})
            2'b10:   pkt_count <= pkt_count + 1'b1;
            2'b01:   pkt_count <= pkt_count - 1'b1;
            default: pkt_count <= pkt_count;
         endcase
      end
   end

   // The full term lets a packet longer than the buffer drain instead of deadlocking.
   assign out_valid = (FULLPACKET != 0) ? ((pkt_count != '0) | full) : ~empty;

   assign out_data  = out_valid ? rd_flit.data  : '0;
   assign out_first = out_valid ? rd_flit.first : 1'b0;
   assign out_last  = out_valid ? rd_flit.last  : 1'b0;
endmodule
